// File: rtl/contador_ajuste_bcd_pkg.sv
// Shared definitions for the BCD field-adjust counter: field width, limits, FSM states
// and the BCD validity helper.
package contador_ajuste_bcd_pkg;

    localparam int BCD_W = 8;

    localparam logic [BCD_W-1:0] SEG_MAX  = 8'h59;
    localparam logic [BCD_W-1:0] MIN_MAX  = 8'h59;
    localparam logic [BCD_W-1:0] HORA_MAX = 8'h23;
    localparam logic [BCD_W-1:0] DIA_MAX  = 8'h31;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } estado_t;

    // True when both nibbles are decimal digits and the value lies within [lo, hi].
    function automatic logic bcd_valido(input logic [BCD_W-1:0] v,
                                        input logic [BCD_W-1:0] lo,
                                        input logic [BCD_W-1:0] hi);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/contador_ajuste_bcd_paso_bcd.sv
// Combinational one-step BCD up/down with carry/borrow between digits and wrap
// between MIN_VAL and MAX_VAL.
module paso_bcd
    import contador_ajuste_bcd_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX_VAL = SEG_MAX,
    parameter logic [BCD_W-1:0] MIN_VAL = 8'h00
) (
    input  logic [BCD_W-1:0] valor,
    input  logic             dir,
    output logic [BCD_W-1:0] siguiente
);

    // Next value: dir=1 counts up, dir=0 counts down.
    always_comb begin
        siguiente = valor;
        if (dir) begin
            if (valor >= MAX_VAL) begin
                siguiente = MIN_VAL;
            end else if (valor[3:0] >= 4'd9) begin
                siguiente = {valor[7:4] + 4'd1, 4'd0};
            end else begin
                siguiente = {valor[7:4], valor[3:0] + 4'd1};
            end
        end else begin
            if (valor <= MIN_VAL) begin
                siguiente = MAX_VAL;
            end else if (valor[3:0] == 4'd0) begin
                siguiente = {valor[7:4] - 4'd1, 4'd9};
            end else begin
                siguiente = {valor[7:4], valor[3:0] - 4'd1};
            end
        end
    end

endmodule

// File: rtl/contador_ajuste_bcd.sv
// Push-button driven 2-digit BCD field editor with edge detect, load and 'cambio' pulse.
// Auto-repeat while a button is held is built only when AUTOREPEAT_EN is defined.
module contador_ajuste_bcd
    import contador_ajuste_bcd_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX_VAL      = SEG_MAX,
    parameter logic [BCD_W-1:0] MIN_VAL      = 8'h00,
    parameter int               REPEAT_DELAY = 25000000,
    parameter int               REPEAT_RATE  = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             incremento,
    input  logic             decremento,
    input  logic             habilitar,
    input  logic             cargar,
    input  logic [BCD_W-1:0] dato_in,
    output logic [BCD_W-1:0] valor,
    output logic             cambio
);

    if ((REPEAT_DELAY < 1) || (REPEAT_RATE < 1)) begin : g_param_chk
        $error("REPEAT_DELAY and REPEAT_RATE must be at least 1");
    end

    logic [BCD_W-1:0] valor_q, valor_d;
    logic             cambio_q, cambio_d;
    logic             inc_q, dec_q;
    logic             rise_inc_s, rise_dec_s;
    logic             paso_s;
    logic [BCD_W-1:0] siguiente_s;

    assign rise_inc_s = incremento & ~inc_q;
    assign rise_dec_s = decremento & ~dec_q;

    // Whenever a step is taken exactly one button is high, so it gives the direction.
    paso_bcd #(
        .MAX_VAL (MAX_VAL),
        .MIN_VAL (MIN_VAL)
    ) u_paso (
        .valor     (valor_q),
        .dir       (incremento),
        .siguiente (siguiente_s)
    );

`ifdef AUTOREPEAT_EN
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] TERM_DELAY  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] TERM_REPEAT = CNT_W'(REPEAT_RATE - 1);

    estado_t          estado_q, estado_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             held_s;

    assign held_s = dir_q ? (incremento & ~decremento) : (decremento & ~incremento);

    // Next-state: load / disable / both-pressed override the hold FSM, which paces repeats.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        paso_s   = 1'b0;
        if (cargar || !habilitar || (incremento && decremento)) begin
            estado_d = ST_IDLE;
            cnt_d    = '0;
        end else begin
            case (estado_q)
                ST_IDLE: begin
                    if (rise_inc_s || rise_dec_s) begin
                        paso_s   = 1'b1;
                        dir_d    = rise_inc_s;
                        cnt_d    = '0;
                        estado_d = ST_DELAY;
                    end else begin
                        estado_d = ST_IDLE;
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    if (!held_s) begin
                        estado_d = ST_IDLE;
                        cnt_d    = '0;
                    end else if (cnt_q == ((estado_q == ST_DELAY) ? TERM_DELAY : TERM_REPEAT)) begin
                        paso_s   = 1'b1;
                        cnt_d    = '0;
                        estado_d = ST_REPEAT;
                    end else begin
                        cnt_d    = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    estado_d = ST_IDLE;
                    cnt_d    = '0;
                end
            endcase
        end
    end

    // Hold FSM state, repeat counter and held-button direction.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= ST_IDLE;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
        end
    end
`else
    // Step decision: one step per isolated rising edge, nothing while held.
    always_comb begin
        paso_s = 1'b0;
        if (cargar || !habilitar || (incremento && decremento)) begin
            paso_s = 1'b0;
        end else if (rise_inc_s || rise_dec_s) begin
            paso_s = 1'b1;
        end else begin
            paso_s = 1'b0;
        end
    end
`endif

    // Field value and change pulse; a load always wins over a step.
    always_comb begin
        valor_d  = valor_q;
        cambio_d = 1'b0;
        if (cargar) begin
            valor_d  = bcd_valido(dato_in, MIN_VAL, MAX_VAL) ? dato_in : MIN_VAL;
            cambio_d = 1'b1;
        end else if (paso_s) begin
            valor_d  = siguiente_s;
            cambio_d = 1'b1;
        end else begin
            valor_d  = valor_q;
            cambio_d = 1'b0;
        end
    end

    // Field, pulse and edge-detect registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            valor_q  <= MIN_VAL;
            cambio_q <= 1'b0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
        end else begin
            valor_q  <= valor_d;
            cambio_q <= cambio_d;
            inc_q    <= incremento;
            dec_q    <= decremento;
        end
    end

    assign valor  = valor_q;
    assign cambio = cambio_q;

endmodule
